cordic_angle_table: RTL
=======================

Name: cordic_angle_table

Overview:
- Responder end of the CORDIC datapath's angle-table read interface.
- The datapath drives a 3-bit table address; this block returns the 16-bit arctangent entry on the data bus the same cycle (combinational read).
- Holds 8 entries of atan(2^-n) in Q8.8 degrees, matching the datapath's {phi,8'd0} angle format.
- Adds a byte-serial configuration port to reprogram entries, and a restore engine that rewrites the defaults.

Parameters:
- DEPTH, 8, number of table entries (address width fixed at 3; DEPTH must be 8).
- W, 16, entry width in bits (Q8.8).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- eab_i  input  3  table address from datapath (n)
- edb_o  output  16  table entry at eab_i, combinational from table registers
- cfg_valid_i  input  1  config byte valid
- cfg_ready_o  output  1  config byte accepted when valid&ready at posedge
- cfg_byte_i  input  8  config byte; low byte first, then high byte
- cfg_addr_i  input  3  target entry; sampled with the high byte
- cfg_restore_i  input  1  single-cycle pulse: rewrite all defaults
- lock_i  input  1  high while a CORDIC run is active; blocks table writes
- busy_o  output  1  restore in progress
- dirty_o  output  1  at least one entry user-written since last reset or restore

Behaviour:
- Reset (async, rst_n=0):
  - Entries load defaults 0..7 = 0x2D00, 0x1A91, 0x0E09, 0x0720, 0x0394, 0x01CA, 0x00E5, 0x0073.
  - FSM=IDLE, busy_o=0, dirty_o=0, cfg_ready_o=0 while in reset, low-byte holding register=0.
  - Reset mid-pair or mid-restore aborts immediately; the table returns to defaults.
- Read path:
  - edb_o = table[eab_i] with zero latency, no handshake.
  - A write to the addressed entry is visible on edb_o from the cycle after the committing edge.
- cfg_ready_o = !lock_i && state!=RESTORE && !cfg_restore_i.
- FSM states: IDLE, LO, RESTORE.
  - IDLE: on accepted byte, store it as the low byte and go to LO.
  - LO: on accepted byte, write table[cfg_addr_i] = {byte, low}, set dirty_o=1, go to IDLE. The write occurs on the accepting edge.
  - lock_i rising while in LO: the state and low byte are held; the pair completes after lock_i falls. No timeout.
  - cfg_restore_i in IDLE or LO: any partial low byte is discarded. Go to RESTORE with counter=0.
  - RESTORE: writes default[counter] to table[counter] each cycle for 8 cycles (counter 0..7). busy_o=1 for exactly those 8 cycles, then IDLE with dirty_o=0.
  - Restore proceeds regardless of lock_i; the controller must not pulse restore during a run.
  - cfg_restore_i while already in RESTORE: ignored, no restart.
- Simultaneous events:
  - cfg_restore_i and cfg_valid_i in the same cycle: restore wins. The byte is not accepted because ready is low that cycle.
  - cfg_valid_i without ready: the byte is held by the sender. No state change.
- Entry values are stored verbatim; no range checking. Signed interpretation is the datapath's concern.
- Counter is 3-bit; restore termination is on counter==7, with no wrap into a second pass.

Test Plan:
- Reset then sweep eab_i 0..7 -> edb_o = 0x2D00, 0x1A91, 0x0E09, 0x0720, 0x0394, 0x01CA, 0x00E5, 0x0073, same cycle as address change; dirty_o=0, busy_o=0.
- Bytes 0x34 then 0x12 with cfg_addr_i=3, eab_i=3 held -> edb_o=0x0720 through the second accepting edge, 0x1234 the next cycle; dirty_o=1; other entries unchanged.
- Low byte 0xAA accepted, lock_i=1 for 5 cycles with cfg_valid_i=1 and high byte 0x55, addr 0 -> cfg_ready_o=0 and entry 0 stays 0x2D00 during lock; after lock_i falls, entry 0 = 0x55AA.
- Write 0xBEEF to entry 7, then pulse cfg_restore_i -> busy_o=1 for exactly 8 cycles, cfg_ready_o=0 throughout; afterwards entry 7 = 0x0073, dirty_o=0.
- Accept low byte 0x11, then cfg_restore_i with cfg_valid_i=1 the same cycle -> byte not accepted; after restore, a new pair 0x22, 0x33 to addr 1 gives 0x3322 (the stale 0x11 is not used).
- Deassert rst_n during restore cycle 4, after entry 5 was user-written -> all outputs return to reset values asynchronously; entry 5 reads its default 0x01CA.

Source files
------------

// File: rtl/cordic_angle_table.sv
// Arctangent lookup table for the CORDIC datapath: zero-latency read port, byte-serial
// reprogramming port and a sequential restore engine that reloads the default entries.
module cordic_angle_table #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   eab_i,
    output logic [W-1:0] edb_o,
    input  logic         cfg_valid_i,
    output logic         cfg_ready_o,
    input  logic [7:0]   cfg_byte_i,
    input  logic [2:0]   cfg_addr_i,
    input  logic         cfg_restore_i,
    input  logic         lock_i,
    output logic         busy_o,
    output logic         dirty_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LO      = 2'd1,
        RESTORE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   entry_q [DEPTH];
    logic [W-1:0]   entry_d [DEPTH];
    logic [7:0]     lo_q, lo_d;
    logic [2:0]     cnt_q, cnt_d;
    logic           dirty_q, dirty_d;
    logic           accept;

    // atan(2^-n) in Q8.8 degrees.
    function automatic logic [W-1:0] default_entry(input logic [2:0] idx);
        case (idx)
            3'd0:    return W'(16'h2D00);
            3'd1:    return W'(16'h1A91);
            3'd2:    return W'(16'h0E09);
            3'd3:    return W'(16'h0720);
            3'd4:    return W'(16'h0394);
            3'd5:    return W'(16'h01CA);
            3'd6:    return W'(16'h00E5);
            default: return W'(16'h0073);
        endcase
    endfunction

    assign edb_o   = entry_q[eab_i];
    assign dirty_o = dirty_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: assigning a default before the case keeps this block free of inferred latches.
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_restore_i) state_d = RESTORE;
                     else if (accept)   state_d = LO;
            LO:      if (cfg_restore_i) state_d = RESTORE;
                     else if (accept)   state_d = IDLE;
            RESTORE: if (cnt_q == 3'd7) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic; ready is forced low in reset and while a restore is requested or running.
    always_comb begin
        busy_o      = (state_q == RESTORE);
        cfg_ready_o = rst_n && !lock_i && (state_q != RESTORE) && !cfg_restore_i;
        accept      = cfg_valid_i && cfg_ready_o;
    end

    // Table, low-byte holder, restore counter and dirty flag next-state.
    always_comb begin
        entry_d = entry_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        dirty_d = dirty_q;
        case (state_q)
            IDLE: begin
                if (cfg_restore_i) begin
                    cnt_d = 3'd0;
                end else if (accept) begin
                    lo_d = cfg_byte_i;
                end
            end
            LO: begin
                if (cfg_restore_i) begin
                    cnt_d = 3'd0;
                    lo_d  = 8'd0;
                end else if (accept) begin
                    entry_d[cfg_addr_i] = {cfg_byte_i, lo_q};
                    dirty_d             = 1'b1;
                end
            end
            RESTORE: begin
                entry_d[cnt_q] = default_entry(cnt_q);
                cnt_d          = cnt_q + 3'd1;
                if (cnt_q == 3'd7) dirty_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the table is a register file, not a RAM, so it is reset to its defaults;
            // a reset mid-write or mid-restore must leave a usable table.
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= default_entry(3'(i));
            lo_q    <= 8'd0;
            cnt_q   <= 3'd0;
            dirty_q <= 1'b0;
        end else begin
            entry_q <= entry_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            dirty_q <= dirty_d;
        end
    end

endmodule
